// File: rtl/change_dispenser.sv
// Output stage behind the autoseller: buffers completed sales, pulses the drink
// release, then pays out change greedily one coin per hopper handshake.
module change_dispenser #(
    parameter int DEPTH    = 4,
    parameter int COIN_HI  = 10,
    parameter int COIN_MID = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_i,
    input  logic [5:0] change_i,
    input  logic [1:0] drink_i,
    output logic       ready_o,
    output logic       drink_valid_o,
    output logic [1:0] drink_o,
    output logic       coin_valid_o,
    output logic [1:0] coin_o,
    input  logic       coin_ack_i,
    output logic       done_o,
    output logic       overflow_o
);

    localparam int              AW   = $clog2(DEPTH);
    localparam int              CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);
    localparam logic [5:0]      HI   = 6'(COIN_HI);
    localparam logic [5:0]      MID  = 6'(COIN_MID);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRINK,
        S_COIN,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [5:0]    r_mem_chg [DEPTH];
    logic [1:0]    r_mem_drk [DEPTH];
    logic [5:0]    r_rem;
    logic [1:0]    r_drk;
    logic          r_drink_valid;
    logic          r_coin_valid;
    logic          r_done;
    logic          r_overflow;

    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_ack;
    logic [1:0]    w_coin_code;
    logic [5:0]    w_coin_val;

    assign w_full = (r_count == FULL);
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
    // A pop in the same cycle frees a slot, so a full FIFO can still take the sale.
    assign w_push = enable_i && (!w_full || w_pop);
    assign w_drop = enable_i && w_full && !w_pop;
    assign w_ack  = (r_state == S_COIN) && coin_ack_i;

    always_comb begin
        w_coin_code = 2'b01;
        w_coin_val  = 6'd1;
        if (r_rem >= HI) begin
            w_coin_code = 2'b11;
            w_coin_val  = HI;
        end else if (r_rem >= MID) begin
            w_coin_code = 2'b10;
            w_coin_val  = MID;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_chg[r_wr_ptr] <= change_i;
            r_mem_drk[r_wr_ptr] <= drink_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_rem         <= '0;
            r_drk         <= '0;
            r_drink_valid <= 1'b0;
            r_coin_valid  <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_rem         <= r_mem_chg[r_rd_ptr];
                        r_drk         <= r_mem_drk[r_rd_ptr];
                        r_drink_valid <= 1'b1;
                        r_state       <= S_DRINK;
                    end
                end
                S_DRINK: begin
                    r_drink_valid <= 1'b0;
                    r_drk         <= '0;
                    if (r_rem != '0) begin
                        r_coin_valid <= 1'b1;
                        r_state      <= S_COIN;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_COIN: begin
                    if (w_ack) begin
                        r_rem <= r_rem - w_coin_val;
                        if (r_rem == w_coin_val) begin
                            r_coin_valid <= 1'b0;
                            r_done       <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o       = !w_full;
    assign drink_valid_o = r_drink_valid;
    assign drink_o       = r_drk;
    assign coin_valid_o  = r_coin_valid;
    assign coin_o        = r_coin_valid ? w_coin_code : 2'b00;
    assign done_o        = r_done;
    assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: table of single sales, corner sequences, and a
// randomized run scored against an event-level model of each sale.
module tb_change_dispenser;

    localparam int DEPTH = 4;
    localparam int HI    = 10;
    localparam int MID   = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable_i;
    logic [5:0] change_i;
    logic [1:0] drink_i;
    logic       coin_ack_i = 1'b0;
    logic       ready_o;
    logic       drink_valid_o;
    logic [1:0] drink_o;
    logic       coin_valid_o;
    logic [1:0] coin_o;
    logic       done_o;
    logic       overflow_o;

    always #5 clk = ~clk;

    change_dispenser #(.DEPTH(DEPTH), .COIN_HI(HI), .COIN_MID(MID)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable_i      (enable_i),
        .change_i      (change_i),
        .drink_i       (drink_i),
        .ready_o       (ready_o),
        .drink_valid_o (drink_valid_o),
        .drink_o       (drink_o),
        .coin_valid_o  (coin_valid_o),
        .coin_o        (coin_o),
        .coin_ack_i    (coin_ack_i),
        .done_o        (done_o),
        .overflow_o    (overflow_o)
    );

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int ack_mode = 0;
    logic ack_val = 1'b0;

    // kind: 0 = drink pulse, 1 = accepted coin, 2 = done pulse
    typedef struct {
        int kind;
        int val;
    } ev_t;
    ev_t exp_q[$];

    typedef struct {
        int chg;
        int drk;
        int coins;
        int lat;
    } vec_t;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Expected output events of one sale, from the greedy coin counts.
    task automatic add_sale(input int chg, input int drk);
        exp_q.push_back('{0, drk});
        repeat (chg / HI)               exp_q.push_back('{1, 3});
        repeat ((chg % HI) / MID)       exp_q.push_back('{1, 2});
        repeat (chg % MID)              exp_q.push_back('{1, 1});
        exp_q.push_back('{2, 0});
    endtask

    task automatic sb(input int kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("sb_unexpected_event", kind * 16 + val, -1);
        end else begin
            e = exp_q.pop_front();
            check("sb_event(kind*16+val)", kind * 16 + val, e.kind * 16 + e.val);
        end
    endtask

    // Ack driver: 0 = follow ack_val, 1 = random, 2 = toggle every cycle.
    initial forever begin
        @(posedge clk);
        #2;
        case (ack_mode)
            1:       coin_ack_i = ($urandom_range(0, 9) < 7);
            2:       coin_ack_i = ~coin_ack_i;
            default: coin_ack_i = ack_val;
        endcase
    end

    // Monitor: scoreboard of observed events plus per-cycle coin rules.
    initial begin
        logic       prev_v;
        logic       prev_a;
        logic [1:0] prev_c;
        prev_v = 1'b0;
        prev_a = 1'b0;
        prev_c = 2'b00;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_v = 1'b0;
            end else begin
                if (drink_valid_o) sb(0, int'(drink_o));
                if (coin_valid_o && coin_ack_i) sb(1, int'(coin_o));
                if (done_o) begin
                    sb(2, 0);
                    done_cnt++;
                end
                if (!coin_valid_o) check("coin_zero_when_idle", int'(coin_o), 0);
                if (prev_v && !prev_a && coin_valid_o)
                    check("coin_held_until_ack", int'(coin_o), int'(prev_c));
                prev_v = coin_valid_o;
                prev_a = coin_ack_i;
                prev_c = coin_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int chg, input int drk, input bit exp_rdy, input bit exp_acc);
        enable_i = 1'b1;
        change_i = 6'(chg);
        drink_i  = 2'(drk);
        @(negedge clk);
        check("ready_before_push", int'(ready_o), int'(exp_rdy));
        @(posedge clk);
        #1;
        enable_i = 1'b0;
        if (exp_acc) add_sale(chg, drk);
    endtask

    task automatic wait_dones(input int n, input int budget);
        int base;
        base = done_cnt;
        for (int i = 0; i < budget && (done_cnt - base) < n; i++) tick();
        repeat (10) tick();
        check("done_pulse_count", done_cnt - base, n);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", int'(ready_o), 1);
        check("rst_drink_valid", int'(drink_valid_o), 0);
        check("rst_drink", int'(drink_o), 0);
        check("rst_coin_valid", int'(coin_valid_o), 0);
        check("rst_coin", int'(coin_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_overflow", int'(overflow_o), 0);
    endtask

    initial begin
        vec_t vecs[8];
        int   lat;
        int   coins;
        int   base;
        int   acc;

        vecs[0] = '{27, 2, 5, 8};
        vecs[1] = '{0,  1, 0, 3};
        vecs[2] = '{63, 3, 9, 12};
        vecs[3] = '{6,  0, 2, 5};
        vecs[4] = '{15, 2, 2, 5};
        vecs[5] = '{4,  1, 4, 7};
        vecs[6] = '{10, 3, 1, 4};
        vecs[7] = '{49, 0, 9, 12};

        reset    = 1'b1;
        enable_i = 1'b0;
        change_i = '0;
        drink_i  = '0;
        #2 reset = 1'b0;
        #2 check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // Single sales with the hopper always ready: latency and coin count.
        ack_val = 1'b1;
        foreach (vecs[i]) begin
            push(vecs[i].chg, vecs[i].drk, 1'b1, 1'b1);
            lat   = -1;
            coins = 0;
            for (int cyc = 1; cyc <= 40; cyc++) begin
                @(posedge clk);
                @(negedge clk);
                if (coin_valid_o && coin_ack_i) coins++;
                if (done_o) begin
                    lat = cyc + 1;
                    break;
                end
            end
            tick();
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_coins", i), coins, vecs[i].coins);
        end
        check("table_sb_empty", exp_q.size(), 0);

        // Change 63 with a toggling ack: coin must hold while unacknowledged.
        ack_mode = 2;
        base = done_cnt;
        push(63, 1, 1'b1, 1'b1);
        for (int i = 0; i < 80 && done_cnt == base; i++) tick();
        repeat (5) tick();
        check("toggle_done_once", done_cnt - base, 1);
        check("toggle_sb_empty", exp_q.size(), 0);
        ack_mode = 0;
        ack_val  = 1'b0;
        tick();

        // Hopper stalled: six back-to-back sales, the sixth is dropped.
        for (int i = 0; i < 6; i++) push(10, i % 4, (i < 5), (i < 5));
        check("ovf_set", int'(overflow_o), 1);
        check("ovf_ready_low", int'(ready_o), 0);
        repeat (3) tick();
        check("ovf_sticky", int'(overflow_o), 1);
        ack_val = 1'b1;
        wait_dones(5, 200);
        check("ovf_still_sticky", int'(overflow_o), 1);
        check("ovf_sb_empty", exp_q.size(), 0);

        // Full FIFO with a pop in the same cycle as the push.
        reset = 1'b0;
        exp_q.delete();
        tick();
        tick();
        reset   = 1'b1;
        ack_val = 1'b0;
        tick();
        push(10, 0, 1'b1, 1'b1);
        repeat (3) tick();
        for (int i = 1; i <= 4; i++) push(10, i % 4, 1'b1, 1'b1);
        check("full_ready_low", int'(ready_o), 0);
        ack_val = 1'b1;
        tick();
        ack_val = 1'b0;
        tick();
        push(10, 1, 1'b0, 1'b1);
        check("pushpop_no_overflow", int'(overflow_o), 0);
        check("pushpop_count_unchanged", int'(ready_o), 0);
        ack_val = 1'b1;
        wait_dones(5, 200);
        check("pushpop_sb_empty", exp_q.size(), 0);
        check("pushpop_overflow_final", int'(overflow_o), 0);

        // Reset in the middle of paying out change 17, with overflow already set.
        ack_val = 1'b0;
        tick();
        push(17, 2, 1'b1, 1'b1);
        for (int i = 1; i < 6; i++) push(10, 0, (i < 5), (i < 5));
        tick();
        check("midrst_ovf_before", int'(overflow_o), 1);
        check("midrst_coin_valid_before", int'(coin_valid_o), 1);
        check("midrst_coin_before", int'(coin_o), 3);
        #2 reset = 1'b0;
        #1 check_reset_outputs();
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        ack_val = 1'b1;
        tick();
        base = done_cnt;
        push(6, 3, 1'b1, 1'b1);
        for (int i = 0; i < 30 && done_cnt == base; i++) tick();
        repeat (3) tick();
        check("postrst_done", done_cnt - base, 1);
        check("postrst_sb_empty", exp_q.size(), 0);

        // Randomized sales and hopper acks, throttled so nothing is dropped.
        ack_mode = 1;
        base = done_cnt;
        acc  = 0;
        for (int s = 0; s < 60; s++) begin
            for (int w = 0; w < 500 && (acc - (done_cnt - base)) >= DEPTH; w++) tick();
            check("rand_throttle", int'((acc - (done_cnt - base)) < DEPTH), 1);
            repeat ($urandom_range(0, 3)) tick();
            push(int'($urandom_range(0, 63)), int'($urandom_range(0, 3)), 1'b1, 1'b1);
            acc++;
        end
        for (int i = 0; i < 4000 && exp_q.size() > 0; i++) tick();
        repeat (5) tick();
        check("rand_drain", exp_q.size(), 0);
        check("rand_done_count", done_cnt - base, 60);
        check("rand_no_overflow", int'(overflow_o), 0);
        ack_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
